// File: rtl/ray_march_engine.sv
// ---------------------------------------------------------------------------
// ray_march_engine
// Sequential sphere-tracing ray marcher. One march step runs:
//   MUL (s = rd*t) -> ADD (pos = ro + s) -> SQ (sum of squares of pos - C)
//   -> SQRT (32 cycles, 1 root bit/cycle) -> EVAL (dS = min(sphere, plane))
//   -> ACC (t += dS, terminate test).
// Scene: sphere centre (0,1,6), radius 1.0, plus ground plane y = 0.
// All datapath values are signed Q16.16 in 32 bits.
//
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous, active-high reset
//   start                1-cycle request, sampled only while idle
//   ro_x/ro_y/ro_z       ray origin (Q16.16), latched on accepted start
//   rd_x/rd_y/rd_z       unit ray direction (Q16.16), latched on accepted start
//   busy                 high while a ray is being marched
//   done                 1-cycle pulse when distance/hit/steps are updated
//   distance             final t (Q16.16), held until the next done
//   hit                  1 = terminated on dS < SURFACE_DIST
//   steps                iterations executed for the last ray
// ---------------------------------------------------------------------------
module ray_march_engine #(
  parameter int unsigned MAX_STEPS    = 100,
  parameter logic [31:0] MAX_DIST     = 32'h0064_0000,
  parameter logic [31:0] SURFACE_DIST = 32'h0000_028F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] ro_x,
  input  logic [31:0] ro_y,
  input  logic [31:0] ro_z,
  input  logic [31:0] rd_x,
  input  logic [31:0] rd_y,
  input  logic [31:0] rd_z,
  output logic        busy,
  output logic        done,
  output logic [31:0] distance,
  output logic        hit,
  output logic [7:0]  steps
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_ADD  = 3'd2,
    S_SQ   = 3'd3,
    S_SQRT = 3'd4,
    S_EVAL = 3'd5,
    S_ACC  = 3'd6
  } state_t;

  localparam logic signed [31:0] ONE_Q      = 32'sh0001_0000;
  localparam logic signed [31:0] CTR_X      = 32'sh0000_0000;
  localparam logic signed [31:0] CTR_Y      = 32'sh0001_0000;
  localparam logic signed [31:0] CTR_Z      = 32'sh0006_0000;
  localparam logic [7:0]         STEP_LIMIT = 8'(MAX_STEPS);

  // Q16.16 multiply: full signed product, arithmetic shift, keep low 32 bits.
  function automatic logic signed [31:0] mul_q16(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    logic signed [63:0] prod;
    prod = 64'(a) * 64'(b);
    return 32'(prod >>> 16);
  endfunction

  // Square of a Q16.16 value as an unsigned Q32.32 quantity.
  function automatic logic [63:0] square_q32(input logic signed [31:0] a);
    logic signed [63:0] prod;
    prod = 64'(a) * 64'(a);
    return prod;
  endfunction

  state_t             state_q, state_d;
  logic signed [31:0] ro_x_q, ro_y_q, ro_z_q, ro_x_d, ro_y_d, ro_z_d;
  logic signed [31:0] rd_x_q, rd_y_q, rd_z_q, rd_x_d, rd_y_d, rd_z_d;
  logic signed [31:0] s_x_q, s_y_q, s_z_q, s_x_d, s_y_d, s_z_d;
  logic signed [31:0] pos_x_q, pos_y_q, pos_z_q, pos_x_d, pos_y_d, pos_z_d;
  logic signed [31:0] t_q, t_d, ds_q, ds_d;
  logic [7:0]         iter_q, iter_d;
  logic [63:0]        rad_q, rad_d;
  logic [33:0]        rem_q, rem_d;
  logic [31:0]        root_q, root_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic               busy_q, busy_d, done_q, done_d, hit_q, hit_d;
  logic [31:0]        distance_q, distance_d;
  logic [7:0]         steps_q, steps_d;

  logic signed [31:0] dlt_x, dlt_y, dlt_z, sphere_ds, t_new;
  logic [65:0]        sum_sq;
  logic [35:0]        rem_shift, rem_trial;
  logic [7:0]         iter_new;

  // Next-state and datapath logic for the whole march sequence.
  always_comb begin
    state_d    = state_q;
    ro_x_d     = ro_x_q;   ro_y_d  = ro_y_q;   ro_z_d  = ro_z_q;
    rd_x_d     = rd_x_q;   rd_y_d  = rd_y_q;   rd_z_d  = rd_z_q;
    s_x_d      = s_x_q;    s_y_d   = s_y_q;    s_z_d   = s_z_q;
    pos_x_d    = pos_x_q;  pos_y_d = pos_y_q;  pos_z_d = pos_z_q;
    t_d        = t_q;
    ds_d       = ds_q;
    iter_d     = iter_q;
    rad_d      = rad_q;
    rem_d      = rem_q;
    root_d     = root_q;
    bit_cnt_d  = bit_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hit_d      = hit_q;
    distance_d = distance_q;
    steps_d    = steps_q;

    dlt_x     = pos_x_q - CTR_X;
    dlt_y     = pos_y_q - CTR_Y;
    dlt_z     = pos_z_q - CTR_Z;
    sum_sq    = {2'b00, square_q32(dlt_x)} + {2'b00, square_q32(dlt_y)}
              + {2'b00, square_q32(dlt_z)};
    // Restoring isqrt: bring down the next radicand bit pair, trial-subtract 4r+1.
    rem_shift = {rem_q, rad_q[63:62]};
    rem_trial = {2'b00, root_q, 2'b01};
    sphere_ds = $signed(root_q) - ONE_Q;
    t_new     = t_q + ds_q;
    iter_new  = iter_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ro_x_d  = ro_x;  ro_y_d = ro_y;  ro_z_d = ro_z;
          rd_x_d  = rd_x;  rd_y_d = rd_y;  rd_z_d = rd_z;
          t_d     = 32'sh0000_0000;
          iter_d  = 8'd0;
          busy_d  = 1'b1;
          state_d = S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        s_x_d   = mul_q16(rd_x_q, t_q);
        s_y_d   = mul_q16(rd_y_q, t_q);
        s_z_d   = mul_q16(rd_z_q, t_q);
        state_d = S_ADD;
      end
      S_ADD: begin
        pos_x_d = ro_x_q + s_x_q;
        pos_y_d = ro_y_q + s_y_q;
        pos_z_d = ro_z_q + s_z_q;
        state_d = S_SQ;
      end
      S_SQ: begin
        // The top bit pair seeds the remainder; its root bit would sit above
        // the 32-bit Q16.16 result and is zero for in-range rays.
        rad_d     = sum_sq[63:0];
        rem_d     = {32'd0, sum_sq[65:64]};
        root_d    = 32'd0;
        bit_cnt_d = 5'd0;
        state_d   = S_SQRT;
      end
      S_SQRT: begin
        if (rem_shift >= rem_trial) begin
          rem_d  = 34'(rem_shift - rem_trial);
          root_d = {root_q[30:0], 1'b1};
        end else begin
          rem_d  = rem_shift[33:0];
          root_d = {root_q[30:0], 1'b0};
        end
        rad_d     = {rad_q[61:0], 2'b00};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd31) begin
          state_d = S_EVAL;
        end else begin
          state_d = S_SQRT;
        end
      end
      S_EVAL: begin
        ds_d    = (sphere_ds < pos_y_q) ? sphere_ds : pos_y_q;
        state_d = S_ACC;
      end
      S_ACC: begin
        t_d    = t_new;
        iter_d = iter_new;
        if ((ds_q < $signed(SURFACE_DIST)) || (t_new > $signed(MAX_DIST)) ||
            (iter_new == STEP_LIMIT)) begin
          // Hit has priority; the other two exits are both misses.
          hit_d      = (ds_q < $signed(SURFACE_DIST));
          distance_d = t_new;
          steps_d    = iter_new;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_MUL;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any ray in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ro_x_q     <= 32'sh0; ro_y_q  <= 32'sh0; ro_z_q  <= 32'sh0;
      rd_x_q     <= 32'sh0; rd_y_q  <= 32'sh0; rd_z_q  <= 32'sh0;
      s_x_q      <= 32'sh0; s_y_q   <= 32'sh0; s_z_q   <= 32'sh0;
      pos_x_q    <= 32'sh0; pos_y_q <= 32'sh0; pos_z_q <= 32'sh0;
      t_q        <= 32'sh0;
      ds_q       <= 32'sh0;
      iter_q     <= 8'd0;
      rad_q      <= 64'd0;
      rem_q      <= 34'd0;
      root_q     <= 32'd0;
      bit_cnt_q  <= 5'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      distance_q <= 32'd0;
      steps_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      ro_x_q     <= ro_x_d;  ro_y_q  <= ro_y_d;  ro_z_q  <= ro_z_d;
      rd_x_q     <= rd_x_d;  rd_y_q  <= rd_y_d;  rd_z_q  <= rd_z_d;
      s_x_q      <= s_x_d;   s_y_q   <= s_y_d;   s_z_q   <= s_z_d;
      pos_x_q    <= pos_x_d; pos_y_q <= pos_y_d; pos_z_q <= pos_z_d;
      t_q        <= t_d;
      ds_q       <= ds_d;
      iter_q     <= iter_d;
      rad_q      <= rad_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      bit_cnt_q  <= bit_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      distance_q <= distance_d;
      steps_q    <= steps_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign distance = distance_q;
  assign hit      = hit_q;
  assign steps    = steps_q;

endmodule

// File: tb/tb_ray_march_engine.sv
// ---------------------------------------------------------------------------
// tb_ray_march_engine
// Directed bench for ray_march_engine. A default instance runs the main
// scenarios; a second instance with MAX_STEPS=3 covers the step limit.
// Cycle counts include the accepting edge: done is seen after edge N where
// edge 1 is the edge that samples start.
// ---------------------------------------------------------------------------
module tb_ray_march_engine;

  localparam logic [31:0] Q0  = 32'h0000_0000;
  localparam logic [31:0] Q1  = 32'h0001_0000;
  localparam logic [31:0] QM1 = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start3 = 1'b0;
  logic [31:0] ro_x = 32'd0, ro_y = 32'd0, ro_z = 32'd0;
  logic [31:0] rd_x = 32'd0, rd_y = 32'd0, rd_z = 32'd0;
  logic        busy, done, hit;
  logic [31:0] distance;
  logic [7:0]  steps;
  logic        busy3, done3, hit3;
  logic [31:0] distance3;
  logic [7:0]  steps3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ray_march_engine dut (
    .clk(clk), .rst(rst), .start(start),
    .ro_x(ro_x), .ro_y(ro_y), .ro_z(ro_z),
    .rd_x(rd_x), .rd_y(rd_y), .rd_z(rd_z),
    .busy(busy), .done(done), .distance(distance), .hit(hit), .steps(steps)
  );

  ray_march_engine #(.MAX_STEPS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .ro_x(ro_x), .ro_y(ro_y), .ro_z(ro_z),
    .rd_x(rd_x), .rd_y(rd_y), .rd_z(rd_z),
    .busy(busy3), .done(done3), .distance(distance3), .hit(hit3), .steps(steps3)
  );

  // Launch one ray and wait (bounded) for done on the chosen instance.
  task automatic run_ray(input logic [31:0] ox, input logic [31:0] oy, input logic [31:0] oz,
                         input logic [31:0] dx, input logic [31:0] dy, input logic [31:0] dz,
                         input bit sel3, input int max_cycles,
                         output int cycles, output bit timed_out);
    @(negedge clk);
    ro_x = ox; ro_y = oy; ro_z = oz;
    rd_x = dx; rd_y = dy; rd_z = dz;
    if (sel3) start3 = 1'b1;
    else      start  = 1'b1;
    cycles    = 0;
    timed_out = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      start3 = 1'b0;
      cycles++;
      if ((sel3 ? done3 : done) === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (distance !== 32'h0) begin errors++; $display("FAIL reset_distance: got %h expected 0", distance); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", hit); end
    checks++; if (steps !== 8'd0) begin errors++; $display("FAIL reset_steps: got %0d expected 0", steps); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_plane_hit();
    int  cyc;
    bit  to;
    run_ray(Q0, Q1, Q0, Q0, QM1, Q0, 1'b0, 100, cyc, to);
    checks++; if (to) begin errors++; $display("FAIL plane_timeout: no done within 100 cycles"); end
    checks++; if (cyc !== 75) begin errors++; $display("FAIL plane_latency: got %0d expected 75", cyc); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL plane_hit: got %b expected 1", hit); end
    checks++; if (steps !== 8'd2) begin errors++; $display("FAIL plane_steps: got %0d expected 2", steps); end
    checks++; if (distance !== 32'h0001_0000) begin errors++; $display("FAIL plane_distance: got %h expected 00010000", distance); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL plane_busy_at_done: got %b expected 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL plane_done_pulse: got %b expected 0", done); end
    checks++; if (distance !== 32'h0001_0000) begin errors++; $display("FAIL plane_distance_held: got %h expected 00010000", distance); end
  endtask

  task automatic test_graze_sphere();
    int                 cyc;
    bit                 to;
    logic signed [31:0] diff;
    run_ray(Q0, Q1, Q0, Q0, Q0, Q1, 1'b0, 300, cyc, to);
    diff = $signed(distance) - 32'sh0005_0000;
    if (diff < 32'sh0) diff = -diff;
    checks++; if (to) begin errors++; $display("FAIL graze_timeout: no done within 300 cycles"); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL graze_hit: got %b expected 1", hit); end
    checks++; if (diff > 32'sh0000_028F) begin errors++; $display("FAIL graze_distance: got %h expected 00050000 +/- 0000028f", distance); end
    checks++; if (steps !== 8'd6) begin errors++; $display("FAIL graze_steps: got %0d expected 6", steps); end
    checks++; if (cyc !== 223) begin errors++; $display("FAIL graze_latency: got %0d expected 223", cyc); end
  endtask

  task automatic test_miss();
    int cyc;
    bit to;
    run_ray(Q0, Q1, Q0, Q0, Q1, Q0, 1'b0, 400, cyc, to);
    checks++; if (to) begin errors++; $display("FAIL miss_timeout: no done within 400 cycles"); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_hit: got %b expected 0", hit); end
    checks++; if (!($signed(distance) > $signed(32'h0064_0000))) begin errors++; $display("FAIL miss_distance: got %h expected > 00640000", distance); end
    checks++; if (!(steps < 8'd100)) begin errors++; $display("FAIL miss_steps_bound: got %0d expected < 100", steps); end
    checks++; if (steps !== 8'd7) begin errors++; $display("FAIL miss_steps: got %0d expected 7", steps); end
  endtask

  task automatic test_max_steps();
    int cyc;
    bit to;
    run_ray(Q0, Q1, Q0, Q0, Q0, Q1, 1'b1, 200, cyc, to);
    checks++; if (to) begin errors++; $display("FAIL maxsteps_timeout: no done within 200 cycles"); end
    checks++; if (hit3 !== 1'b0) begin errors++; $display("FAIL maxsteps_hit: got %b expected 0", hit3); end
    checks++; if (steps3 !== 8'd3) begin errors++; $display("FAIL maxsteps_steps: got %0d expected 3", steps3); end
    checks++; if (distance3 !== 32'h0003_0000) begin errors++; $display("FAIL maxsteps_distance: got %h expected 00030000", distance3); end
  endtask

  task automatic test_busy_start();
    int          done_cnt;
    int          first_cyc;
    logic        first_hit;
    logic [7:0]  first_steps;
    logic [31:0] first_dist;
    done_cnt = 0; first_cyc = 0; first_hit = 1'b0; first_steps = 8'd0; first_dist = 32'd0;
    @(negedge clk);
    ro_x = Q0; ro_y = Q1; ro_z = Q0;
    rd_x = Q0; rd_y = QM1; rd_z = Q0;
    start = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (i == 10) begin
        // Upward (missing) ray offered while busy; must be dropped.
        rd_y  = Q1;
        start = 1'b1;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          first_cyc   = i;
          first_hit   = hit;
          first_steps = steps;
          first_dist  = distance;
        end
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", done_cnt); end
    checks++; if (first_cyc !== 75) begin errors++; $display("FAIL busy_latency: got %0d expected 75", first_cyc); end
    checks++; if (first_hit !== 1'b1) begin errors++; $display("FAIL busy_hit: got %b expected 1", first_hit); end
    checks++; if (first_steps !== 8'd2) begin errors++; $display("FAIL busy_steps: got %0d expected 2", first_steps); end
    checks++; if (first_dist !== 32'h0001_0000) begin errors++; $display("FAIL busy_distance: got %h expected 00010000", first_dist); end
  endtask

  task automatic test_reset_mid_ray();
    int cyc;
    bit to;
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    ro_x = Q0; ro_y = Q1; ro_z = Q0;
    rd_x = Q0; rd_y = QM1; rd_z = Q0;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    checks++; if (distance !== 32'h0) begin errors++; $display("FAIL midrst_distance: got %h expected 0", distance); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL midrst_hit: got %b expected 0", hit); end
    checks++; if (steps !== 8'd0) begin errors++; $display("FAIL midrst_steps: got %0d expected 0", steps); end
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_cnt++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_cnt); end
    run_ray(Q0, Q1, Q0, Q0, QM1, Q0, 1'b0, 100, cyc, to);
    checks++; if (to) begin errors++; $display("FAIL midrst_rerun_timeout: no done within 100 cycles"); end
    checks++; if (cyc !== 75) begin errors++; $display("FAIL midrst_rerun_latency: got %0d expected 75", cyc); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL midrst_rerun_hit: got %b expected 1", hit); end
    checks++; if (steps !== 8'd2) begin errors++; $display("FAIL midrst_rerun_steps: got %0d expected 2", steps); end
    checks++; if (distance !== 32'h0001_0000) begin errors++; $display("FAIL midrst_rerun_distance: got %h expected 00010000", distance); end
  endtask

  initial begin
    test_reset();
    test_plane_hit();
    test_graze_sphere();
    test_miss();
    test_max_steps();
    test_busy_start();
    test_reset_mid_ray();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
